i2c_slave_rx_shifter: RTL and testbench

Receive-side serial-in/parallel-out shifter for the I2C slave. It oversamples the bus with the system clock and detects START and STOP conditions. It assembles address and write-data bytes MSB-first and drives the ACK/NACK bit on SDA. It complements the slave transmit shifter, which handles read data: this block owns the slave's view of the bus on every write phase and on the address phase of every transaction.

---
 rtl/i2c_slave_rx_shifter.sv | 169 ++++++++++++++++
 tb/tb_i2c_slave_rx_shifter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_rx_shifter.sv
// I2C slave receive shifter: START/STOP detect, address match, MSB-first byte assembly, ACK drive on SDA.
// Latency: a raw bus edge is acted on 3 clk edges after it changes; no backpressure, Data/DataValid are fire-and-forget.
module i2c_slave_rx_shifter #(
    parameter logic [6:0] ADDR = 7'h42
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       scl_i,
    input  logic       sda_i,
    input  logic       ack_en_i,
    output logic       sda_oe_o,
    output logic [7:0] data_o,
    output logic       data_valid_o,
    output logic       addr_match_o,
    output logic       rw_bit_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_DATA,
        S_DATA_ACK,
        S_IGNORE
    } state_t;

    logic scl_s1_q, scl_s2_q, scl_p_q;
    logic sda_s1_q, sda_s2_q, sda_p_q;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       dv_pend_q, dv_pend_d;
    logic       dv_q, dv_d;
    logic       oe_q, oe_d;
    logic       match_q, match_d;
    logic       rw_q, rw_d;
    logic       busy_q, busy_d;

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] shift_nxt;

    // Synchronisers track the bus even through reset so the history is valid on release.
    always_ff @(posedge clk_i) begin
        scl_s1_q <= scl_i;
        scl_s2_q <= scl_s1_q;
        scl_p_q  <= scl_s2_q;
        sda_s1_q <= sda_i;
        sda_s2_q <= sda_s1_q;
        sda_p_q  <= sda_s2_q;
    end

    assign scl_rise  = scl_s2_q & ~scl_p_q;
    assign scl_fall  = ~scl_s2_q & scl_p_q;
    assign start_det = ~sda_s2_q & sda_p_q & scl_s2_q & scl_p_q;
    assign stop_det  = sda_s2_q & ~sda_p_q & scl_s2_q & scl_p_q;
    assign shift_nxt = {shift_q[6:0], sda_s2_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        dv_pend_d = 1'b0;
        dv_d      = dv_pend_q;
        oe_d      = oe_q;
        match_d   = match_q;
        rw_d      = rw_q;
        busy_d    = busy_q;

        if (start_det) begin
            state_d = S_ADDR;
            cnt_d   = 4'd0;
            shift_d = 8'h00;
            oe_d    = 1'b0;
            match_d = 1'b0;
            busy_d  = 1'b1;
        end else if (stop_det) begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
            match_d = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_DATA: begin
                    if (scl_rise) begin
                        shift_d = shift_nxt;
                        if (cnt_q != 4'd8) begin
                            cnt_d = cnt_q + 4'd1;
                        end
                        if (state_q == S_DATA && cnt_q == 4'd7) begin
                            data_d    = shift_nxt;
                            dv_pend_d = 1'b1;
                        end
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        if (state_q == S_DATA) begin
                            state_d = S_DATA_ACK;
                            oe_d    = ack_en_i;
                        end else if (shift_q[7:1] == ADDR) begin
                            state_d = S_ADDR_ACK;
                            oe_d    = 1'b1;
                            match_d = 1'b1;
                            rw_d    = shift_q[0];
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    // Read phases belong to the transmit shifter.
                    if (scl_fall) begin
                        oe_d    = 1'b0;
                        cnt_d   = 4'd0;
                        state_d = rw_q ? S_IGNORE : S_DATA;
                    end
                end
                S_DATA_ACK: begin
                    if (scl_fall) begin
                        oe_d    = 1'b0;
                        cnt_d   = 4'd0;
                        state_d = S_DATA;
                    end
                end
                S_IGNORE: begin
                    oe_d = 1'b0;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            dv_pend_q <= 1'b0;
            dv_q      <= 1'b0;
            oe_q      <= 1'b0;
            match_q   <= 1'b0;
            rw_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            dv_pend_q <= dv_pend_d;
            dv_q      <= dv_d;
            oe_q      <= oe_d;
            match_q   <= match_d;
            rw_q      <= rw_d;
            busy_q    <= busy_d;
        end
    end

    assign sda_oe_o     = oe_q;
    assign data_o       = data_q;
    assign data_valid_o = dv_q;
    assign addr_match_o = match_q;
    assign rw_bit_o     = rw_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_i2c_slave_rx_shifter.sv
// Bench for i2c_slave_rx_shifter: drives an open-drain I2C master model, scoreboards received data bytes.
module tb_i2c_slave_rx_shifter;

    logic       clk;
    logic       rst;
    logic       scl_drv;
    logic       sda_drv;
    logic       ack_en;
    logic       sda_oe;
    logic [7:0] data;
    logic       data_valid;
    logic       addr_match;
    logic       rw_bit;
    logic       busy;
    logic       sda_bus;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    logic [7:0]  exp_q[$];
    logic        dv_prev = 1'b0;
    logic        oe_seen = 1'b0;

    assign sda_bus = sda_drv & ~sda_oe;

    i2c_slave_rx_shifter #(.ADDR(7'h42)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .scl_i        (scl_drv),
        .sda_i        (sda_bus),
        .ack_en_i     (ack_en),
        .sda_oe_o     (sda_oe),
        .data_o       (data),
        .data_valid_o (data_valid),
        .addr_match_o (addr_match),
        .rw_bit_o     (rw_bit),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Scoreboard: every DataValid pulse must be single-cycle and match the oldest byte driven.
    always @(posedge clk) begin
        #1;
        if (data_valid) begin
            chk("dv_single", {31'd0, dv_prev}, 32'd0);
            chk("dv_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) chk("data", {24'd0, data}, {24'd0, exp_q.pop_front()});
        end
        dv_prev = data_valid;
        if (sda_oe) oe_seen = 1'b1;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_cond();
        if (scl_drv == 1'b0) begin
            sda_drv = 1'b1;
            wait_clks(5);
            scl_drv = 1'b1;
            wait_clks(5);
        end
        sda_drv = 1'b0;
        wait_clks(5);
        scl_drv = 1'b0;
        wait_clks(5);
    endtask

    task automatic stop_cond();
        sda_drv = 1'b0;
        wait_clks(5);
        scl_drv = 1'b1;
        wait_clks(5);
        sda_drv = 1'b1;
        wait_clks(6);
    endtask

    task automatic send_bit(input logic b);
        sda_drv = b;
        wait_clks(2);
        scl_drv = 1'b1;
        wait_clks(5);
        scl_drv = 1'b0;
        wait_clks(3);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic ack_clock(input string tag, input logic exp_oe);
        sda_drv = 1'b1;
        wait_clks(2);
        scl_drv = 1'b1;
        wait_clks(3);
        chk(tag, {31'd0, sda_oe}, {31'd0, exp_oe});
        wait_clks(2);
        scl_drv = 1'b0;
        wait_clks(3);
    endtask

    initial begin
        rst     = 1'b1;
        scl_drv = 1'b1;
        sda_drv = 1'b1;
        ack_en  = 1'b1;
        wait_clks(6);
        chk("rst_oe",    {31'd0, sda_oe},     32'd0);
        chk("rst_data",  {24'd0, data},       32'd0);
        chk("rst_dv",    {31'd0, data_valid}, 32'd0);
        chk("rst_match", {31'd0, addr_match}, 32'd0);
        chk("rst_rw",    {31'd0, rw_bit},     32'd0);
        chk("rst_busy",  {31'd0, busy},       32'd0);
        rst = 1'b0;
        wait_clks(4);

        // Write 0x42 <- 0xA5, ACKed
        start_cond();
        chk("w1_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h84);
        ack_clock("w1_addr_ack", 1'b1);
        chk("w1_match", {31'd0, addr_match}, 32'd1);
        chk("w1_rw",    {31'd0, rw_bit},     32'd0);
        ack_en = 1'b1;
        exp_q.push_back(8'hA5);
        send_byte(8'hA5);
        ack_clock("w1_data_ack", 1'b1);
        stop_cond();
        chk("w1_busy_end",  {31'd0, busy},       32'd0);
        chk("w1_match_end", {31'd0, addr_match}, 32'd0);
        chk("w1_drained",   exp_q.size(),        32'd0);

        // Address 0x43: not for us
        oe_seen = 1'b0;
        start_cond();
        send_byte(8'h86);
        ack_clock("nm_addr_ack", 1'b0);
        chk("nm_match", {31'd0, addr_match}, 32'd0);
        send_byte(8'h11);
        ack_clock("nm_data_ack", 1'b0);
        chk("nm_busy", {31'd0, busy}, 32'd1);
        stop_cond();
        chk("nm_oe_never", {31'd0, oe_seen}, 32'd0);
        chk("nm_busy_end", {31'd0, busy},    32'd0);

        // Read from 0x42: ACK address, then stay off the bus
        start_cond();
        send_byte(8'h85);
        ack_clock("rd_addr_ack", 1'b1);
        chk("rd_rw",    {31'd0, rw_bit},     32'd1);
        chk("rd_match", {31'd0, addr_match}, 32'd1);
        oe_seen = 1'b0;
        send_byte(8'h5A);
        send_bit(1'b1);
        stop_cond();
        chk("rd_oe_never", {31'd0, oe_seen}, 32'd0);

        // Two data bytes, second NACKed
        start_cond();
        send_byte(8'h84);
        ack_clock("w2_addr_ack", 1'b1);
        ack_en = 1'b1;
        exp_q.push_back(8'h00);
        send_byte(8'h00);
        ack_clock("w2_ack1", 1'b1);
        ack_en = 1'b0;
        exp_q.push_back(8'hFF);
        send_byte(8'hFF);
        ack_clock("w2_ack2", 1'b0);
        stop_cond();
        chk("w2_drained", exp_q.size(), 32'd0);

        // Repeated START after 4 data bits discards the partial byte
        ack_en = 1'b1;
        start_cond();
        send_byte(8'h84);
        ack_clock("rs_addr_ack", 1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        start_cond();
        chk("rs_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h84);
        ack_clock("rs_addr_ack2", 1'b1);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C);
        ack_clock("rs_data_ack", 1'b1);
        stop_cond();
        chk("rs_data",    {24'd0, data}, 32'h3C);
        chk("rs_drained", exp_q.size(),  32'd0);

        // Reset while driving the address ACK
        start_cond();
        send_byte(8'h85);
        sda_drv = 1'b1;
        wait_clks(2);
        scl_drv = 1'b1;
        wait_clks(2);
        chk("ra_oe_pre", {31'd0, sda_oe}, 32'd1);
        chk("ra_rw_pre", {31'd0, rw_bit}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("ra_oe",    {31'd0, sda_oe},     32'd0);
        chk("ra_data",  {24'd0, data},       32'd0);
        chk("ra_dv",    {31'd0, data_valid}, 32'd0);
        chk("ra_match", {31'd0, addr_match}, 32'd0);
        chk("ra_rw",    {31'd0, rw_bit},     32'd0);
        chk("ra_busy",  {31'd0, busy},       32'd0);
        wait_clks(3);
        rst = 1'b0;
        scl_drv = 1'b0;
        wait_clks(5);
        stop_cond();
        chk("end_drained", exp_q.size(), 32'd0);
        chk("end_busy", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
